dcache_write_buffer: RTL and testbench

//  Posted write buffer between the dcache memory-side port and memory_control.

---
 rtl/dcache_write_buffer.sv | 174 +++++++++++++++++
 tb/tb_dcache_write_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_write_buffer.sv
// -----------------------------------------------------------------------------
// dcache_write_buffer
//   Posted write buffer between the dcache memory-side port and memory_control.
//   Cache writes are captured in a small FIFO and complete without waiting on
//   RAM latency. Entries drain to memory_control one word at a time. Reads go
//   to memory in program order, or are forwarded from the buffer when enabled.
//
//   Optional feature macro: WB_FORWARD_EN
//     defined   - reads that hit a buffered entry are answered in the same
//                 cycle from the youngest match; misses bypass pending drains.
//     undefined - no compare logic; a read waits until the buffer is empty.
//
// Ports
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   c_dREN, c_dWEN       cache read / write request
//   c_daddr, c_dstore    cache request address / write data
//   c_dwait, c_dload     stall to cache / read data to cache
//   m_dREN, m_dWEN       read / write request to memory_control
//   m_daddr, m_dstore    address / write data to memory_control
//   m_dwait, m_dload     memory_control stall / read data
//   wb_empty             buffer empty and FSM idle (halt/flush qualifier)
// -----------------------------------------------------------------------------
module dcache_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        c_dREN,
    input  logic        c_dWEN,
    input  logic [31:0] c_daddr,
    input  logic [31:0] c_dstore,
    output logic        c_dwait,
    output logic [31:0] c_dload,
    output logic        m_dREN,
    output logic        m_dWEN,
    output logic [31:0] m_daddr,
    output logic [31:0] m_dstore,
    input  logic        m_dwait,
    input  logic [31:0] m_dload,
    output logic        wb_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t          state, state_next;
    logic [29:0]     addr_mem [DEPTH];
    logic [31:0]     data_mem [DEPTH];
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic            full, push, pop;
    logic            fwd_hit;
    logic [31:0]     fwd_data;
    logic            read_eligible;

    assign full = (count == CW'(DEPTH));
    assign push = c_dWEN & ~full;
    assign pop  = (state == WRITE) & ~m_dwait;

    // NOTE: storage carries no reset; an entry is only ever read while count
    // covers it, so clearing the array would cost flops for nothing.
    always_ff @(posedge CLK) begin
        if (push) begin
            addr_mem[head] <= c_daddr[31:2];
            data_mem[head] <= c_dstore;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) head <= head + 1'b1;   // wraps modulo DEPTH (power of 2)
            if (pop)  tail <= tail + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef WB_FORWARD_EN
    // Scan oldest to youngest so the last hit written is the youngest entry.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = tail + PW'(i);
            if ((CW'(i) < count) && (addr_mem[idx] == c_daddr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[idx];
            end
        end
    end
    // A miss cannot alias any buffered entry, so it may overtake the drain.
    assign read_eligible = ~fwd_hit;
`else
    assign fwd_hit       = 1'b0;
    assign fwd_data      = '0;
    // Strict program order: the buffer drains completely before a read.
    assign read_eligible = (count == '0);
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (c_dREN && !c_dWEN && read_eligible)
                    state_next = READ;
                else if ((count != '0) || push)   // start on the entry being pushed now
                    state_next = WRITE;
            end
            WRITE: if (!m_dwait) state_next = IDLE;
            READ:  if (!c_dREN || !m_dwait) state_next = IDLE;   // drop abandons the read
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        m_dREN   = 1'b0;
        m_dWEN   = 1'b0;
        m_daddr  = '0;
        m_dstore = '0;
        c_dload  = '0;
        c_dwait  = 1'b0;

        case (state)
            WRITE: begin
                m_dWEN   = 1'b1;
                m_daddr  = {addr_mem[tail], 2'b00};
                m_dstore = data_mem[tail];
            end
            READ: begin
                m_dREN  = 1'b1;
                m_daddr = c_daddr;
                c_dload = m_dload;
            end
            default: ;
        endcase

        // Writes win over reads; the write-side stall never sees m_dwait.
        if (c_dWEN) begin
            c_dwait = full;
        end else if (c_dREN) begin
            if (state == READ) begin
                c_dwait = m_dwait;
            end else if (fwd_hit) begin
                c_dwait = 1'b0;
                c_dload = fwd_data;
            end else begin
                c_dwait = 1'b1;
            end
        end
    end

    assign wb_empty = (count == '0) && (state == IDLE);

endmodule

// File: tb/tb_dcache_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_dcache_write_buffer
//   Directed, table-driven bench for dcache_write_buffer. Each table row is one
//   clock cycle: inputs are driven after the falling edge and the outputs are
//   compared 1 ns later, before the next rising edge. A hand-written sequence
//   covers an asynchronous reset in the middle of a drain.
// -----------------------------------------------------------------------------
module tb_dcache_write_buffer;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        c_dREN, c_dWEN;
    logic [31:0] c_daddr, c_dstore;
    logic        c_dwait;
    logic [31:0] c_dload;
    logic        m_dREN, m_dWEN;
    logic [31:0] m_daddr, m_dstore;
    logic        m_dwait;
    logic [31:0] m_dload;
    logic        wb_empty;

    int checks   = 0;
    int failures = 0;

    dcache_write_buffer #(.DEPTH(4)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .c_dREN   (c_dREN),
        .c_dWEN   (c_dWEN),
        .c_daddr  (c_daddr),
        .c_dstore (c_dstore),
        .c_dwait  (c_dwait),
        .c_dload  (c_dload),
        .m_dREN   (m_dREN),
        .m_dWEN   (m_dWEN),
        .m_daddr  (m_daddr),
        .m_dstore (m_dstore),
        .m_dwait  (m_dwait),
        .m_dload  (m_dload),
        .wb_empty (wb_empty)
    );

    always #5 CLK = ~CLK;

    // One cycle: inputs then expected outputs.
    typedef struct {
        logic [31:0] ren, wen, addr, store, mwait, mload;
        logic [31:0] e_cwait, e_cload, e_mren, e_mwen, e_maddr, e_mstore, e_empty;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        input logic [31:0] ren, wen, addr, store, mwait, mload,
        input logic [31:0] cw, cl, mr, mw, ma, ms, em
    );
        vec_t r;
        r = '{ren, wen, addr, store, mwait, mload, cw, cl, mr, mw, ma, ms, em};
        return r;
    endfunction

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ren, wen, addr, store, mwait, mload);
        c_dREN   = ren[0];
        c_dWEN   = wen[0];
        c_daddr  = addr;
        c_dstore = store;
        m_dwait  = mwait[0];
        m_dload  = mload;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge CLK);
            drive(tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].store, tbl[i].mwait, tbl[i].mload);
            #1;
            check({tag, ".c_dwait"},  i, {31'b0, c_dwait},  tbl[i].e_cwait);
            check({tag, ".c_dload"},  i, c_dload,           tbl[i].e_cload);
            check({tag, ".m_dREN"},   i, {31'b0, m_dREN},   tbl[i].e_mren);
            check({tag, ".m_dWEN"},   i, {31'b0, m_dWEN},   tbl[i].e_mwen);
            check({tag, ".m_daddr"},  i, m_daddr,           tbl[i].e_maddr);
            check({tag, ".m_dstore"}, i, m_dstore,          tbl[i].e_mstore);
            check({tag, ".wb_empty"}, i, {31'b0, wb_empty}, tbl[i].e_empty);
        end
        tbl.delete();
    endtask

    localparam logic [31:0] DA4 = 32'hA4A4_0001;
    localparam logic [31:0] DB8 = 32'hB8B8_0002;
    localparam logic [31:0] D04 = 32'h0404_0003;
    localparam logic [31:0] DE0 = 32'hE0E0_0004;
    localparam logic [31:0] D08 = 32'h0808_0005;

    initial begin
        nRST = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        // Reset state, single posted write, fill to full and drain in order.
        //             ren wen addr   store        mw mload  cw cload mr mw maddr  mstore       em
        tbl.push_back(v(0, 0, 0,     0,           0, 0,     0, 0,    0, 0, 0,     0,           1));
        tbl.push_back(v(0, 1, 'hE0,  'hBEEFDEAD,  0, 0,     0, 0,    0, 0, 0,     0,           1));
        tbl.push_back(v(0, 0, 0,     0,           0, 0,     0, 0,    0, 1, 'hE0,  'hBEEFDEAD,  0));
        tbl.push_back(v(0, 0, 0,     0,           0, 0,     0, 0,    0, 0, 0,     0,           1));
        tbl.push_back(v(0, 1, 'hA4,  DA4,         1, 0,     0, 0,    0, 0, 0,     0,           1));
        tbl.push_back(v(0, 1, 'hB8,  DB8,         1, 0,     0, 0,    0, 1, 'hA4,  DA4,         0));
        tbl.push_back(v(0, 1, 'h04,  D04,         1, 0,     0, 0,    0, 1, 'hA4,  DA4,         0));
        tbl.push_back(v(0, 1, 'hE0,  DE0,         1, 0,     0, 0,    0, 1, 'hA4,  DA4,         0));
        tbl.push_back(v(0, 1, 'h08,  D08,         1, 0,     1, 0,    0, 1, 'hA4,  DA4,         0));
        tbl.push_back(v(0, 1, 'h08,  D08,         0, 0,     1, 0,    0, 1, 'hA4,  DA4,         0));
        tbl.push_back(v(0, 1, 'h08,  D08,         1, 0,     0, 0,    0, 0, 0,     0,           0));
        tbl.push_back(v(0, 0, 0,     0,           0, 0,     0, 0,    0, 1, 'hB8,  DB8,         0));
        tbl.push_back(v(0, 0, 0,     0,           1, 0,     0, 0,    0, 0, 0,     0,           0));
        tbl.push_back(v(0, 0, 0,     0,           0, 0,     0, 0,    0, 1, 'h04,  D04,         0));
        tbl.push_back(v(0, 0, 0,     0,           0, 0,     0, 0,    0, 0, 0,     0,           0));
        tbl.push_back(v(0, 0, 0,     0,           0, 0,     0, 0,    0, 1, 'hE0,  DE0,         0));
        tbl.push_back(v(0, 0, 0,     0,           0, 0,     0, 0,    0, 0, 0,     0,           0));
        tbl.push_back(v(0, 0, 0,     0,           0, 0,     0, 0,    0, 1, 'h08,  D08,         0));
        tbl.push_back(v(0, 0, 0,     0,           0, 0,     0, 0,    0, 0, 0,     0,           1));
        run_table("fifo");

`ifdef WB_FORWARD_EN
        // Forwarding: youngest of two matching entries, a miss, hit during pop.
        tbl.push_back(v(0, 1, 'hA4,  'hAAAABBBB,  1, 0,     0, 0,           0, 0, 0,    0,           1));
        tbl.push_back(v(0, 1, 'hA4,  'hC4C4C4C4,  1, 0,     0, 0,           0, 1, 'hA4, 'hAAAABBBB,  0));
        tbl.push_back(v(1, 0, 'hA4,  0,           1, 0,     0, 'hC4C4C4C4,  0, 1, 'hA4, 'hAAAABBBB,  0));
        tbl.push_back(v(1, 0, 'h1A4, 0,           1, 0,     1, 0,           0, 1, 'hA4, 'hAAAABBBB,  0));
        tbl.push_back(v(1, 0, 'hA4,  0,           0, 0,     0, 'hC4C4C4C4,  0, 1, 'hA4, 'hAAAABBBB,  0));
        tbl.push_back(v(1, 0, 'hA4,  0,           1, 0,     0, 'hC4C4C4C4,  0, 0, 0,    0,           0));
        tbl.push_back(v(0, 0, 0,     0,           0, 0,     0, 0,           0, 1, 'hA4, 'hC4C4C4C4,  0));
        tbl.push_back(v(0, 0, 0,     0,           0, 0,     0, 0,           0, 0, 0,    0,           1));
        run_table("fwd");
`else
        // Program order: read waits for the drain; read/write priority; read abandon.
        tbl.push_back(v(0, 1, 'h04,  'hB00B1111,  1, 0,           0, 0,           0, 0, 0,    0,           1));
        tbl.push_back(v(1, 0, 'h08,  0,           1, 0,           1, 0,           0, 1, 'h04, 'hB00B1111,  0));
        tbl.push_back(v(1, 0, 'h08,  0,           1, 0,           1, 0,           0, 1, 'h04, 'hB00B1111,  0));
        tbl.push_back(v(1, 0, 'h08,  0,           0, 0,           1, 0,           0, 1, 'h04, 'hB00B1111,  0));
        tbl.push_back(v(1, 0, 'h08,  0,           1, 0,           1, 0,           0, 0, 0,    0,           1));
        tbl.push_back(v(1, 0, 'h08,  0,           1, 'hDEADBEEF,  1, 'hDEADBEEF,  1, 0, 'h08, 0,           0));
        tbl.push_back(v(1, 0, 'h08,  0,           0, 'h5A5A0008,  0, 'h5A5A0008,  1, 0, 'h08, 0,           0));
        tbl.push_back(v(0, 0, 0,     0,           0, 0,           0, 0,           0, 0, 0,    0,           1));
        tbl.push_back(v(1, 1, 'h10,  'h12345678,  1, 0,           0, 0,           0, 0, 0,    0,           1));
        tbl.push_back(v(1, 0, 'h20,  0,           1, 0,           1, 0,           0, 1, 'h10, 'h12345678,  0));
        tbl.push_back(v(1, 0, 'h20,  0,           0, 0,           1, 0,           0, 1, 'h10, 'h12345678,  0));
        tbl.push_back(v(1, 0, 'h20,  0,           1, 0,           1, 0,           0, 0, 0,    0,           1));
        tbl.push_back(v(1, 0, 'h20,  0,           1, 0,           1, 0,           1, 0, 'h20, 0,           0));
        tbl.push_back(v(0, 0, 0,     0,           1, 0,           0, 0,           1, 0, 0,    0,           0));
        tbl.push_back(v(0, 0, 0,     0,           0, 0,           0, 0,           0, 0, 0,    0,           1));
        run_table("order");
`endif

        // Three entries queued, then reset mid-drain.
        tbl.push_back(v(0, 1, 'h100, 'h0000_0101, 1, 0,  0, 0, 0, 0, 0,      0,            1));
        tbl.push_back(v(0, 1, 'h104, 'h0000_0102, 1, 0,  0, 0, 0, 1, 'h100,  'h0000_0101,  0));
        tbl.push_back(v(0, 1, 'h108, 'h0000_0103, 1, 0,  0, 0, 0, 1, 'h100,  'h0000_0101,  0));
        run_table("prefill");

        @(negedge CLK);
        drive(0, 0, 0, 0, 1, 0);
        #1;
        check("rst.m_dWEN_before", 0, {31'b0, m_dWEN}, 32'd1);
        #2 nRST = 1'b0;
        #1;
        check("rst.m_dWEN_async",  0, {31'b0, m_dWEN},   32'd0);
        check("rst.m_daddr_async", 0, m_daddr,           32'd0);
        check("rst.wb_empty_in",   0, {31'b0, wb_empty}, 32'd1);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        check("rst.wb_empty_after", 0, {31'b0, wb_empty}, 32'd1);

        // The next write is accepted and drained from a cleared FIFO.
        tbl.push_back(v(0, 1, 'h200, 'h0000_0202, 0, 0,  0, 0, 0, 0, 0,      0,            1));
        tbl.push_back(v(0, 0, 0,     0,           0, 0,  0, 0, 0, 1, 'h200,  'h0000_0202,  0));
        tbl.push_back(v(0, 0, 0,     0,           0, 0,  0, 0, 0, 0, 0,      0,            1));
        run_table("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
